// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: stage registers and fetch-stage definitions.
package rv32i_types;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
   localparam int          ORDER_S_W        = 64;

   typedef enum logic {
      ISSUE = 1'b0,
      WAIT  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]          pc_s;
      logic [31:0]          pc_next_s;
      logic [ORDER_S_W-1:0] order_s;
      logic                 valid_s;
   } if_id_stage_reg_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one word read outstanding at a time,
// and discards the response of a request made stale by a redirect.
module if_fetch
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ORDER_W  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_in,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      imem_addr,
   output logic [3:0]       imem_rmask,
   input  logic             imem_resp,
   output logic             fetch_resp_valid,
   output if_id_stage_reg_t if_id_reg
);

   fetch_state_t        state;
   logic [31:0]         pc;
   logic [31:0]         req_pc;
   logic [ORDER_W-1:0]  order;
   logic                drop_pending;

   logic                issue;
   logic                deliver;
   logic [31:0]         redirect_target;
   logic [31:0]         req_pc_next4;

   // rst gates issue so the read mask stays quiet while the stage is held in reset.
   always_comb begin
      issue            = rst && (state == ISSUE) && !stall_in && !redirect_valid;
      deliver          = (state == WAIT) && imem_resp && !drop_pending;
      redirect_target  = redirect_pc & ~32'h3;
      req_pc_next4     = req_pc + 32'd4;
      imem_addr        = (state == ISSUE) ? pc : req_pc;
      imem_rmask       = issue ? 4'hF : 4'h0;
      fetch_resp_valid = deliver;
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values; later assignments in the block override earlier defaults.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ISSUE;
         pc           <= RESET_PC;
         req_pc       <= RESET_PC;
         order        <= '0;
         drop_pending <= 1'b0;
         if_id_reg    <= '0;
      end else begin
         if_id_reg.valid_s <= 1'b0;

         if (state == ISSUE) begin
            if (redirect_valid) begin
               pc <= redirect_target;
            end else if (!stall_in) begin
               req_pc <= pc;
               state  <= WAIT;
            end
         end else begin
            if (imem_resp) begin
               state <= ISSUE;
               if (drop_pending) begin
                  drop_pending <= 1'b0;
               end else begin
                  if_id_reg <= '{pc_s:      req_pc,
                                 pc_next_s: req_pc_next4,
                                 order_s:   ORDER_S_W'(order),
                                 valid_s:   1'b1};
                  order     <= order + ORDER_W'(1);
                  pc        <= req_pc_next4;
               end
            end else if (redirect_valid) begin
               drop_pending <= 1'b1;
            end
            // A redirect always wins the PC, even over a same-cycle sequential update.
            if (redirect_valid) pc <= redirect_target;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus random stall/redirect/latency
// traffic, compared against a transaction-level model of the fetch rules.
module tb_if_fetch;
   import rv32i_types::*;

   localparam logic [31:0] RST_PC = 32'h1eceb000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall_in = 1'b0;
   logic             redirect_valid = 1'b0;
   logic [31:0]      redirect_pc = '0;
   logic             imem_resp = 1'b0;
   logic [31:0]      imem_addr;
   logic [3:0]       imem_rmask;
   logic             fetch_resp_valid;
   if_id_stage_reg_t if_id_reg;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RST_PC), .ORDER_W(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_in         (stall_in),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_addr        (imem_addr),
      .imem_rmask       (imem_rmask),
      .imem_resp        (imem_resp),
      .fetch_resp_valid (fetch_resp_valid),
      .if_id_reg        (if_id_reg)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: next fetch address, retire order, the outstanding request and whether
   // a redirect has made it stale, plus the expected stage register.
   logic [31:0] m_pc, m_out_addr;
   logic [63:0] m_order;
   logic        m_out, m_stale;
   int          m_cnt;
   int          lat;
   logic [31:0] e_pc_s, e_pc_next_s;
   logic [63:0] e_order_s;
   logic        e_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_out_addr = RST_PC; m_order = '0;
      m_out = 1'b0; m_stale = 1'b0; m_cnt = 0;
      e_pc_s = '0; e_pc_next_s = '0; e_order_s = '0; e_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rmask"},     imem_rmask, 4'h0);
      check({tag, " addr"},      imem_addr, RST_PC);
      check({tag, " resp_vld"},  fetch_resp_valid, 1'b0);
      check({tag, " pc_s"},      if_id_reg.pc_s, 32'h0);
      check({tag, " pc_next_s"}, if_id_reg.pc_next_s, 32'h0);
      check({tag, " order_s"},   if_id_reg.order_s, 64'h0);
      check({tag, " valid_s"},   if_id_reg.valid_s, 1'b0);
   endtask

   // One clock: drive inputs at the falling edge, check outputs, then advance the model
   // to what the coming rising edge must produce.
   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
      logic resp, exp_issue;
      @(negedge clk);
      resp = 1'b0;
      if (m_out) begin
         m_cnt--;
         resp = (m_cnt == 0);
      end
      stall_in = st; redirect_valid = rd; redirect_pc = rpc; imem_resp = resp;
      #1;
      exp_issue = !m_out && !st && !rd;
      check("pc_s",      if_id_reg.pc_s, e_pc_s);
      check("pc_next_s", if_id_reg.pc_next_s, e_pc_next_s);
      check("order_s",   if_id_reg.order_s, e_order_s);
      check("valid_s",   if_id_reg.valid_s, e_valid);
      check("rmask",     imem_rmask, exp_issue ? 4'hF : 4'h0);
      check("addr",      imem_addr, m_out ? m_out_addr : m_pc);
      check("resp_vld",  fetch_resp_valid, resp && !m_stale);

      e_valid = 1'b0;
      if (exp_issue) begin
         m_out = 1'b1; m_out_addr = m_pc; m_stale = 1'b0; m_cnt = lat;
      end else if (m_out && resp) begin
         if (!m_stale) begin
            e_pc_s = m_out_addr; e_pc_next_s = m_out_addr + 32'd4;
            e_order_s = m_order; e_valid = 1'b1;
            m_order++;
            m_pc = m_out_addr + 32'd4;
         end
         m_out = 1'b0; m_stale = 1'b0;
         if (rd) m_pc = rpc & ~32'h3;
      end else if (rd) begin
         m_pc = rpc & ~32'h3;
         if (m_out) m_stale = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      lat = 1;
      #1 rst = 1'b0;
      #1 check_reset_outputs("reset");
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;

      // Back-to-back fetches with single-cycle memory.
      cycle(0, 0, 0); check("t1 addr0", imem_addr, 32'h1eceb000);
      cycle(0, 0, 0);
      cycle(0, 0, 0); check("t1 addr1", imem_addr, 32'h1eceb004);
      check("t1 pc_s0", if_id_reg.pc_s, 32'h1eceb000);
      check("t1 ord0", if_id_reg.order_s, 64'd0);
      cycle(0, 0, 0);

      // Stall in ISSUE for five cycles, then release at the same address.
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      check("t2 pc_s1", if_id_reg.pc_s, 32'h1eceb004);
      check("t2 ord1", if_id_reg.order_s, 64'd1);
      lat = 4;
      cycle(0, 0, 0);
      check("t2 addr", imem_addr, 32'h1eceb008);
      check("t2 rmask", imem_rmask, 4'hF);

      // Four-cycle memory latency.
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);

      // Redirect two cycles before the response: that response is dropped.
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 1, 32'h1eceb100);
      cycle(0, 0, 0);
      lat = 1;
      cycle(0, 0, 0);
      check("t4 dropped", fetch_resp_valid, 1'b0);
      cycle(0, 0, 0);
      check("t4 addr", imem_addr, 32'h1eceb100);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check("t4 pc_s", if_id_reg.pc_s, 32'h1eceb100);
      check("t4 order", if_id_reg.order_s, 64'd3);

      // Redirect coincident with the response: delivered, then fetch from the aligned target.
      cycle(0, 1, 32'h1eceb203);
      check("t5 delivered", fetch_resp_valid, 1'b1);
      lat = 4;
      cycle(0, 0, 0);
      check("t5 valid_s", if_id_reg.valid_s, 1'b1);
      check("t5 addr", imem_addr, 32'h1eceb200);

      // Asynchronous reset between edges while a request is outstanding.
      cycle(0, 0, 0);
      #2 rst = 1'b0;
      imem_resp = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
      #1 check_reset_outputs("async rst");
      model_reset();
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      lat = 1;
      cycle(0, 0, 0); check("t6 addr", imem_addr, 32'h1eceb000);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check("t6 pc_s", if_id_reg.pc_s, 32'h1eceb000);
      check("t6 order", if_id_reg.order_s, 64'd0);

      // Random stalls, redirects and memory latencies.
      for (int i = 0; i < 400; i++) begin
         lat = int'($urandom_range(1, 4));
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
